led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent LED channels (1..16).
REQ-002 Parameter DIV_W, default 24: width of the per-channel step divider.
REQ-003 Parameter PWM_W, default 8: width of PWM counter, duty and breathe level.
REQ-004 Port CLK  input  1: single system clock (100 MHz PLL output); all logic SHALL run in this one clock domain.
REQ-005 Port RST_N  input  1: reset, asynchronous assert, active-low.
REQ-006 Port CFG_VALID  input  1: configuration write request.
REQ-007 Port CFG_READY  output  1: block can accept a configuration write.
REQ-008 Port CFG_CH  input  max(1,$clog2(CHANNELS)): target channel index.
REQ-009 Port CFG_MODE  input  2: 00 OFF, 01 ON (dimmed), 10 BLINK, 11 BREATHE.
REQ-010 Port CFG_DIV  input  DIV_W: step period minus one, in CLK cycles.
REQ-011 Port CFG_DUTY  input  PWM_W: brightness for ON mode.
REQ-012 Port LED  output  CHANNELS: registered LED drive, bit i = channel i.

Function
REQ-013 A free-running pwm_cnt (PWM_W bits) SHALL increment every CLK and wrap from all-ones to 0.
REQ-014 Each channel SHALL hold a div counter counting 0..DIV; at DIV it emits a one-cycle step and returns to 0; DIV=0 steps every cycle.
REQ-015 OFF: LED bit SHALL be 0.
REQ-016 ON: LED bit SHALL be (pwm_cnt < DUTY); DUTY all-ones SHALL give constant 1, DUTY 0 constant 0.
REQ-017 BLINK: a phase bit SHALL toggle on every step; LED bit = phase, giving period 2*(DIV+1) cycles.
REQ-018 BREATHE: level SHALL move one count per step under a two-state FSM UP/DOWN; UP at all-ones -> DOWN, DOWN at 0 -> UP; the turning step changes state only, not level; LED bit = (pwm_cnt < level).
REQ-019 LED SHALL be registered: one CLK latency from the compared counter values to the pin.
REQ-020 A write SHALL be accepted when CFG_VALID and CFG_READY are both 1 on a rising CLK edge.
REQ-021 CFG_READY SHALL drop to 0 for exactly the one cycle after an accepted write, then return to 1.
REQ-022 On acceptance, the target channel SHALL load MODE/DIV/DUTY and clear div counter, phase and level, with FSM set to UP; the new mode SHALL drive LED from the following cycle.
REQ-023 CFG_CH >= CHANNELS SHALL be accepted with normal handshake and change no state.
REQ-024 Writes to one channel SHALL not disturb any other channel's counters or phase.

Reset
REQ-025 While RST_N=0: LED=0, CFG_READY=1, pwm_cnt=0, every channel MODE=OFF, DIV=0, DUTY=0, counters/phase/level=0, FSM=UP.
REQ-026 Reset asserted mid-pattern SHALL clear LED immediately (asynchronously), without waiting for CLK.

Configuration
REQ-027 Macro LED_PATTERN_BREATHE_EN defined: BREATHE mode, level registers and UP/DOWN FSM SHALL be present.
REQ-028 Macro undefined: level/FSM logic SHALL be absent; mode 11 SHALL behave as OFF; all other modes unchanged.

Structure
REQ-029 Package led_pattern_pkg SHALL hold the mode encoding type, the breathe FSM state type and the mode constants.
REQ-030 Per-channel logic SHALL be sub-module led_pattern_channel, instantiated CHANNELS times; pwm_cnt and the handshake SHALL stay in the top.

Verification
REQ-031 Reset release, no writes -> LED=0 and CFG_READY=1 for 1000 cycles.
REQ-032 Write ch0 BLINK DIV=3 -> LED[0] toggles every 4 cycles (period 8), first toggle 4 cycles after the first active cycle; LED[3:1] stay 0.
REQ-033 Write ch1 ON DUTY=64, PWM_W=8 -> LED[1] high exactly 64 of every 256 cycles; DUTY=255 -> constantly high.
REQ-034 Write ch2 BREATHE DIV=0 (macro defined) -> level ramps 0..255 then 255..0, full triangle period 512 steps; macro undefined -> LED[2]=0.
REQ-035 CFG_VALID held high for 3 cycles with CFG_CH=5 then CFG_CH=0 -> READY pattern 1,0,1; CH=5 write changes nothing; CH=0 write applied.
REQ-036 RST_N pulsed low mid-BLINK between clock edges -> LED clears before the next CLK edge; all channels return to OFF.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// ---------------------------------------------------------------------------
// led_pattern_pkg
// Shared types and constants for the LED pattern generator:
//   - led_mode_e      : per-channel mode encoding (OFF / ON / BLINK / BREATHE)
//   - breathe_state_e : direction of the breathe ramp (UP / DOWN)
//   - MODE_RESET      : mode every channel takes while reset is asserted
// Optional feature macro: LED_PATTERN_BREATHE_EN (BREATHE mode hardware).
// ---------------------------------------------------------------------------
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } led_mode_e;

  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } breathe_state_e;

  localparam led_mode_e MODE_RESET = MODE_OFF;

endpackage

// File: rtl/led_pattern_channel.sv
// ---------------------------------------------------------------------------
// led_pattern_channel
// One LED channel: holds its configuration, a step divider, the blink phase
// and (when LED_PATTERN_BREATHE_EN is defined) the breathe level and its
// UP/DOWN FSM. Produces one registered LED bit.
// Ports:
//   CLK, RST_N  : system clock, asynchronous active-low reset
//   load        : one-cycle strobe, load cfg_* and restart the pattern
//   cfg_mode    : 2-bit mode (see led_mode_e)
//   cfg_div     : step period minus one, in CLK cycles
//   cfg_duty    : ON-mode brightness
//   pwm_cnt     : shared free-running PWM counter from the top
//   led         : registered LED drive
// Macro: LED_PATTERN_BREATHE_EN enables BREATHE; otherwise mode 11 is OFF.
// ---------------------------------------------------------------------------
module led_pattern_channel
  import led_pattern_pkg::*;
#(
  parameter int DIV_W = 24,
  parameter int PWM_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [PWM_W-1:0] cfg_duty,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  led_mode_e        mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [PWM_W-1:0] duty_q;
  logic             phase_q;
  logic             step;
  logic             led_next;

  // The divider counts 0..div_q; reaching div_q is the step, so div_q=0 steps
  // every cycle.
  assign step = (div_cnt_q == div_q);

  // Configuration registers, step divider and blink phase. A load restarts
  // the pattern from a known point instead of continuing mid-period.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q    <= MODE_RESET;
      div_q     <= '0;
      duty_q    <= '0;
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else if (load) begin
      mode_q    <= led_mode_e'(cfg_mode);
      div_q     <= cfg_div;
      duty_q    <= cfg_duty;
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else if (step) begin
      div_cnt_q <= '0;
      phase_q   <= ~phase_q;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

`ifdef LED_PATTERN_BREATHE_EN
  breathe_state_e   state_q, state_d;
  logic [PWM_W-1:0] level_q, level_d;

  // Breathe FSM state and level register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= BR_UP;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // The level moves one count per step. At either end the step only turns
  // the direction around, so the peak and the floor each last a full step
  // and the triangle spans 2^(PWM_W+1) steps.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (load) begin
      state_d = BR_UP;
      level_d = '0;
    end else if (step && (mode_q == MODE_BREATHE)) begin
      case (state_q)
        BR_UP: begin
          if (level_q == PWM_MAX) state_d = BR_DOWN;
          else                    level_d = level_q + PWM_W'(1);
        end
        BR_DOWN: begin
          if (level_q == '0) state_d = BR_UP;
          else               level_d = level_q - PWM_W'(1);
        end
        default: state_d = BR_UP;
      endcase
    end
  end
`endif

  // LED decode. A full-scale duty must be solid on, which the plain compare
  // against the wrapping counter cannot produce, hence the extra term.
  always_comb begin
    led_next = 1'b0;
    case (mode_q)
      MODE_ON:      led_next = (duty_q == PWM_MAX) || (pwm_cnt < duty_q);
      MODE_BLINK:   led_next = phase_q;
`ifdef LED_PATTERN_BREATHE_EN
      MODE_BREATHE: led_next = (pwm_cnt < level_q);
`else
      MODE_BREATHE: led_next = 1'b0;
`endif
      default:      led_next = 1'b0;
    endcase
  end

  // Registered output so the pin never glitches on decode changes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) led <= 1'b0;
    else        led <= led_next;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
// Multi-channel LED pattern generator (OFF / dimmed ON / BLINK / BREATHE).
// Holds the shared PWM counter and the configuration handshake; each channel
// is a led_pattern_channel instance.
// Ports:
//   CLK, RST_N : system clock, asynchronous active-low reset
//   CFG_VALID  : configuration write request
//   CFG_READY  : write can be accepted (low for one cycle after each write)
//   CFG_CH     : target channel; out-of-range indices are accepted and ignored
//   CFG_MODE   : 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   CFG_DIV    : step period minus one
//   CFG_DUTY   : ON-mode brightness
//   LED        : registered LED drive, bit i = channel i
// Macro: LED_PATTERN_BREATHE_EN enables BREATHE; otherwise mode 11 is OFF.
// ---------------------------------------------------------------------------
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int DIV_W    = 24,
  parameter  int PWM_W    = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CFG_VALID,
  output logic                CFG_READY,
  input  logic [CH_W-1:0]     CFG_CH,
  input  logic [1:0]          CFG_MODE,
  input  logic [DIV_W-1:0]    CFG_DIV,
  input  logic [PWM_W-1:0]    CFG_DUTY,
  output logic [CHANNELS-1:0] LED
);

  logic [PWM_W-1:0] pwm_cnt_q;
  logic             cfg_ready_q;
  logic             accept;

  assign accept    = CFG_VALID && cfg_ready_q;
  assign CFG_READY = cfg_ready_q;

  // Shared PWM counter; wraps naturally from all-ones to zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pwm_cnt_q <= '0;
    else        pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end

  // Ready drops for exactly the cycle after an accepted write, which also
  // blocks back-to-back writes from a held CFG_VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cfg_ready_q <= 1'b1;
    else        cfg_ready_q <= !accept;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic load;

    // An index that matches no channel completes the handshake but loads
    // nothing.
    assign load = accept && (CFG_CH == CH_W'(i));

    led_pattern_channel #(
      .DIV_W(DIV_W),
      .PWM_W(PWM_W)
    ) u_channel (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .load    (load),
      .cfg_mode(CFG_MODE),
      .cfg_div (CFG_DIV),
      .cfg_duty(CFG_DUTY),
      .pwm_cnt (pwm_cnt_q),
      .led     (LED[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed self-checking bench for led_pattern_gen (5 channels so that an
// out-of-range channel index such as 5 is representable on CFG_CH).
// Expected LED values come from hand-derived formulas and a small breathe
// level model; pwm_cnt after the n-th edge since reset release is n mod 256.
// Macro: LED_PATTERN_BREATHE_EN selects the breathe expectations.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;

  localparam int CHANNELS = 5;
  localparam int DIV_W    = 24;
  localparam int PWM_W    = 8;
  localparam int CH_W     = 3;

  localparam logic [1:0] M_OFF     = 2'b00;
  localparam logic [1:0] M_ON      = 2'b01;
  localparam logic [1:0] M_BLINK   = 2'b10;
  localparam logic [1:0] M_BREATHE = 2'b11;

  logic                CLK = 1'b0;
  logic                RST_N;
  logic                CFG_VALID;
  logic                CFG_READY;
  logic [CH_W-1:0]     CFG_CH;
  logic [1:0]          CFG_MODE;
  logic [DIV_W-1:0]    CFG_DIV;
  logic [PWM_W-1:0]    CFG_DUTY;
  logic [CHANNELS-1:0] LED;

  int testsRun  = 0;
  int failCount = 0;
  int cyc       = 0;
  int cycBlink  = 0;

  led_pattern_gen #(
    .CHANNELS(CHANNELS),
    .DIV_W   (DIV_W),
    .PWM_W   (PWM_W)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CFG_VALID(CFG_VALID),
    .CFG_READY(CFG_READY),
    .CFG_CH   (CFG_CH),
    .CFG_MODE (CFG_MODE),
    .CFG_DIV  (CFG_DIV),
    .CFG_DUTY (CFG_DUTY),
    .LED      (LED)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 ns past it; cyc counts edges since
  // the last reset release.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One configuration write; returns just after the accepting edge.
  task automatic applyStimulus(input int ch, input logic [1:0] mode,
                               input int div, input int duty);
    if (CFG_READY !== 1'b1) tick();
    CFG_CH    = CH_W'(ch);
    CFG_MODE  = mode;
    CFG_DIV   = DIV_W'(div);
    CFG_DUTY  = PWM_W'(duty);
    CFG_VALID = 1'b1;
    tick();
    CFG_VALID = 1'b0;
  endtask

  // BLINK with DIV=3 on ch0: LED after the k-th edge past the write edge.
  function automatic int blinkExp();
    int k;
    k = cyc - cycBlink;
    return ((k - 1) / 4) % 2;
  endfunction

  initial begin
    int bad, bad2, cnt, highs, expHighs, mlevel, found;
    bit mup, expLed;

    RST_N     = 1'b0;
    CFG_VALID = 1'b0;
    CFG_CH    = '0;
    CFG_MODE  = M_OFF;
    CFG_DIV   = '0;
    CFG_DUTY  = '0;

    // Reset state.
    #22;
    checkOutput("reset_led", 32'(LED), 0);
    checkOutput("reset_ready", 32'(CFG_READY), 1);
    RST_N = 1'b1;
    cyc   = 0;

    // Idle for 1000 cycles without writes.
    bad = 0;
    repeat (1000) begin
      tick();
      if (LED !== '0 || CFG_READY !== 1'b1) bad++;
    end
    checkOutput("idle_1000", 32'(bad), 0);

    // BLINK on ch0, DIV=3.
    applyStimulus(0, M_BLINK, 3, 0);
    cycBlink = cyc;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checkOutput($sformatf("blink_k%0d", k), 32'(LED[0]), 32'(blinkExp()));
    end
    checkOutput("blink_others", 32'(LED[4:1]), 0);

    // ON on ch1, DUTY=64 then 255.
    applyStimulus(1, M_ON, 0, 64);
    tick();
    tick();
    cnt = 0;
    repeat (256) begin
      tick();
      cnt += int'(LED[1]);
    end
    checkOutput("on_duty64", 32'(cnt), 64);
    checkOutput("blink_undisturbed1", 32'(LED[0]), 32'(blinkExp()));

    applyStimulus(1, M_ON, 0, 255);
    tick();
    tick();
    cnt = 0;
    repeat (256) begin
      tick();
      cnt += int'(LED[1]);
    end
    checkOutput("on_duty255", 32'(cnt), 256);
    checkOutput("blink_undisturbed2", 32'(LED[0]), 32'(blinkExp()));

    // BREATHE on ch2, DIV=0: one step per cycle.
    applyStimulus(2, M_BREATHE, 0, 0);
    mlevel   = 0;
    mup      = 1'b1;
    bad      = 0;
    highs    = 0;
    expHighs = 0;
    repeat (1100) begin
`ifdef LED_PATTERN_BREATHE_EN
      expLed = ((cyc % 256) < mlevel);
`else
      expLed = 1'b0;
`endif
      if (mup) begin
        if (mlevel == 255) mup = 1'b0;
        else               mlevel++;
      end else begin
        if (mlevel == 0) mup = 1'b1;
        else             mlevel--;
      end
      tick();
      if (LED[2] !== expLed) bad++;
      highs    += int'(LED[2]);
      expHighs += int'(expLed);
    end
    checkOutput("breathe_trace", 32'(bad), 0);
    checkOutput("breathe_highs", 32'(highs), 32'(expHighs));
    checkOutput("blink_undisturbed3", 32'(LED[0]), 32'(blinkExp()));

    // Handshake: VALID held 3 cycles, CH=5 then CH=0.
    CFG_CH    = 3'd5;
    CFG_MODE  = M_BLINK;
    CFG_DIV   = '0;
    CFG_DUTY  = '0;
    CFG_VALID = 1'b1;
    checkOutput("hs_ready_c1", 32'(CFG_READY), 1);
    tick();
    checkOutput("hs_ready_c2", 32'(CFG_READY), 0);
    CFG_CH   = 3'd0;
    CFG_MODE = M_OFF;
    tick();
    checkOutput("hs_ready_c3", 32'(CFG_READY), 1);
    tick();
    CFG_VALID = 1'b0;
    checkOutput("hs_ready_after", 32'(CFG_READY), 0);
    tick();
    tick();
    bad  = 0;
    bad2 = 0;
    cnt  = 0;
    repeat (10) begin
      tick();
      if (LED[0] !== 1'b0) bad++;
      if (LED[1] !== 1'b1) bad2++;
      if (LED[4:3] !== 2'b00) cnt++;
    end
    checkOutput("hs_ch0_off", 32'(bad), 0);
    checkOutput("hs_ch1_kept", 32'(bad2), 0);
    checkOutput("hs_ch34_kept", 32'(cnt), 0);

    // Asynchronous reset in the middle of a fast BLINK.
    applyStimulus(0, M_BLINK, 0, 0);
    tick();
    found = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (LED[0] === 1'b1) begin
        found = 1;
        break;
      end
    end
    checkOutput("rst_pre_blink_high", 32'(found), 1);
    #3;
    RST_N = 1'b0;
    #1;
    checkOutput("rst_async_led", 32'(LED), 0);
    checkOutput("rst_async_ready", 32'(CFG_READY), 1);
    #2;
    RST_N = 1'b1;
    cyc   = 0;
    bad   = 0;
    repeat (20) begin
      tick();
      if (LED !== '0) bad++;
    end
    checkOutput("rst_all_off", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
